// File: rtl/block_serializer.sv
// Parallel-to-serial block converter: captures a BLOCK_WIDTH block and emits it MSB word first over valid/ready.
// Optional synchronous clear input cl is built in when BLOCK_SERIALIZER_CLEAR_EN is defined.
module block_serializer #(
    parameter int BLOCK_WIDTH = 128,
    parameter int WORD_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
`ifdef BLOCK_SERIALIZER_CLEAR_EN
    input  logic                   cl,
`endif
    input  logic                   load,
    input  logic [BLOCK_WIDTH-1:0] din,
    output logic                   busy,
    output logic [WORD_WIDTH-1:0]  dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic                   last
);
    localparam int NWORDS = BLOCK_WIDTH / WORD_WIDTH;
    localparam int CW     = $clog2(NWORDS);
    localparam logic [CW-1:0] LAST_IDX = CW'(NWORDS - 1);

    typedef enum logic {IDLE, SEND} state_e;

    state_e                            state_q, state_d;
    logic [NWORDS-1:0][WORD_WIDTH-1:0] buf_q, buf_d;
    logic [CW-1:0]                     cnt_q, cnt_d;
    logic [CW-1:0]                     nxt_cnt;
    logic [WORD_WIDTH-1:0]             dout_q, dout_d;
    logic                              last_q, last_d;

    // Word k of the block lives in the high end: packed index NWORDS-1-k.
    function automatic logic [WORD_WIDTH-1:0] word_at(
        input logic [NWORDS-1:0][WORD_WIDTH-1:0] b,
        input logic [CW-1:0]                     k
    );
        return b[LAST_IDX - k];
    endfunction

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        last_d  = last_q;
        nxt_cnt = cnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (load) begin
                    buf_d   = din;
                    cnt_d   = '0;
                    dout_d  = din[BLOCK_WIDTH-1 -: WORD_WIDTH];
                    last_d  = 1'b0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (dout_ready) begin
                    if (last_q) begin
                        // Counter parks at NWORDS-1; the next load clears it.
                        state_d = IDLE;
                        dout_d  = '0;
                        last_d  = 1'b0;
                    end else begin
                        cnt_d  = nxt_cnt;
                        dout_d = word_at(buf_q, nxt_cnt);
                        last_d = (nxt_cnt == LAST_IDX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef BLOCK_SERIALIZER_CLEAR_EN
        if (cl) begin
            state_d = IDLE;
            buf_d   = '0;
            cnt_d   = '0;
            dout_d  = '0;
            last_d  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            last_q  <= last_d;
        end
    end

    assign busy       = (state_q == SEND);
    assign dout_valid = (state_q == SEND);
    assign dout       = dout_q;
    assign last       = last_q;

endmodule

// File: tb/tb_block_serializer.sv
// Randomized and directed bench for block_serializer (32-bit block, 8-bit words) against a word-queue model.
module tb_block_serializer;
    localparam int BW = 32;
    localparam int WW = 8;
    localparam int NW = BW / WW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          load = 1'b0;
    logic          dout_ready = 1'b0;
    logic [BW-1:0] din = '0;
    logic          busy, dout_valid, last;
    logic [WW-1:0] dout;
`ifdef BLOCK_SERIALIZER_CLEAR_EN
    logic          cl = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Model: words still owed to the sink, front = word on dout.
    logic [WW-1:0] mq[$];

    always #5 clk = ~clk;

    block_serializer #(.BLOCK_WIDTH(BW), .WORD_WIDTH(WW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef BLOCK_SERIALIZER_CLEAR_EN
        .cl         (cl),
`endif
        .load       (load),
        .din        (din),
        .busy       (busy),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .last       (last)
    );

    // {busy, dout_valid, last, dout} expected from the model queue
    function automatic logic [WW+2:0] exp_vec();
        if (mq.size() == 0) return '0;
        return {1'b1, 1'b1, (mq.size() == 1) ? 1'b1 : 1'b0, mq[0]};
    endfunction

    task automatic step(input logic ld, input logic [BW-1:0] d, input logic rdy, input logic c);
        load = ld;
        din = d;
        dout_ready = rdy;
`ifdef BLOCK_SERIALIZER_CLEAR_EN
        cl = c;
`endif
        @(posedge clk);
        if (c) mq.delete();
        else if (mq.size() > 0) begin
            if (rdy) void'(mq.pop_front());
        end else if (ld) begin
            for (int k = 0; k < NW; k++) mq.push_back(d[BW-1-k*WW -: WW]);
        end
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        mq.delete();
        n_cmp++;
        if ({busy, dout_valid, last, dout} !== 11'h0) begin
            n_bad++;
            $display("FAIL reset: got %h want %h", {busy, dout_valid, last, dout}, 11'h0);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
            n_cmp++;
            if ({busy, dout_valid, last, dout} !== exp_vec()) begin
                n_bad++;
                $display("FAIL reset_idle cyc%0d: got %h want %h", i, {busy, dout_valid, last, dout}, exp_vec());
            end
        end
    endtask

    task automatic test_basic();
        logic [BW-1:0] blk = 32'hA1B2C3D4;
        step(1'b1, blk, 1'b1, 1'b0);
        for (int i = 0; i < NW; i++) begin
            n_cmp++;
            if ({busy, dout_valid, last, dout} !== exp_vec() ||
                dout !== blk[BW-1-i*WW -: WW] || last !== (i == NW-1)) begin
                n_bad++;
                $display("FAIL basic word%0d: got %h want %h (word %h)", i,
                         {busy, dout_valid, last, dout}, exp_vec(), blk[BW-1-i*WW -: WW]);
            end
            step(1'b0, '0, 1'b1, 1'b0);
        end
        n_cmp++;
        if (busy !== 1'b0 || dout_valid !== 1'b0 || dout !== 8'h00) begin
            n_bad++;
            $display("FAIL basic_done: got busy=%b valid=%b dout=%h want 0 0 00", busy, dout_valid, dout);
        end
    endtask

    task automatic test_backpressure();
        logic [BW-1:0] blk = 32'hA1B2C3D4;
        logic [WW-1:0] got[$];
        logic          rdy;
        step(1'b1, blk, 1'b1, 1'b0);
        for (int c = 0; c < NW + 3; c++) begin
            rdy = !(c >= 1 && c <= 3);
            n_cmp++;
            if ({busy, dout_valid, last, dout} !== exp_vec()) begin
                n_bad++;
                $display("FAIL backpressure cyc%0d: got %h want %h", c, {busy, dout_valid, last, dout}, exp_vec());
            end
            if (c >= 1 && c <= 3) begin
                n_cmp++;
                if (dout !== 8'hB2 || dout_valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL backpressure_hold cyc%0d: got %h/%b want b2/1", c, dout, dout_valid);
                end
            end
            if (dout_valid && rdy) got.push_back(dout);
            step(1'b0, '0, rdy, 1'b0);
        end
        n_cmp++;
        if (got.size() != NW || got[0] !== 8'hA1 || got[1] !== 8'hB2 || got[2] !== 8'hC3 || got[3] !== 8'hD4) begin
            n_bad++;
            $display("FAIL backpressure_seq: got %0d words want a1 b2 c3 d4", got.size());
        end
    endtask

    task automatic test_load_busy();
        step(1'b1, 32'hA1B2C3D4, 1'b1, 1'b0);
        // load asserted on C3 and on the D4 transfer cycle, then one cycle later
        for (int c = 0; c < 9; c++) begin
            n_cmp++;
            if ({busy, dout_valid, last, dout} !== exp_vec()) begin
                n_bad++;
                $display("FAIL load_busy cyc%0d: got %h want %h", c, {busy, dout_valid, last, dout}, exp_vec());
            end
            step((c == 2 || c == 3 || c == 4) ? 1'b1 : 1'b0, 32'h11223344, 1'b1, 1'b0);
        end
        n_cmp++;
        if (dout_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL load_busy_end: got valid=%b want 0", dout_valid);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 32'hA1B2C3D4, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        mq.delete();
        n_cmp++;
        if ({busy, dout_valid, last, dout} !== 11'h0) begin
            n_bad++;
            $display("FAIL reset_mid_async: got %h want %h", {busy, dout_valid, last, dout}, 11'h0);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            n_cmp++;
            if ({busy, dout_valid, last, dout} !== exp_vec()) begin
                n_bad++;
                $display("FAIL reset_mid_after cyc%0d: got %h want %h", i, {busy, dout_valid, last, dout}, exp_vec());
            end
        end
    endtask

`ifdef BLOCK_SERIALIZER_CLEAR_EN
    task automatic test_clear();
        step(1'b1, 32'hA1B2C3D4, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 32'h55667788, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({busy, dout_valid, last, dout} !== exp_vec()) begin
                n_bad++;
                $display("FAIL clear cyc%0d: got %h want %h", i, {busy, dout_valid, last, dout}, exp_vec());
            end
            step(1'b0, '0, 1'b1, 1'b0);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0, $urandom,
                 ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 1'b0);
            n_cmp++;
            if ({busy, dout_valid, last, dout} !== exp_vec()) begin
                n_bad++;
                $display("FAIL random cyc%0d: got %h want %h", i, {busy, dout_valid, last, dout}, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_load_busy();
        test_reset_mid();
`ifdef BLOCK_SERIALIZER_CLEAR_EN
        test_clear();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
